// File: rtl/wb_cache_arbiter_pkg.sv
// rtl/wb_cache_arbiter_pkg.sv - shared types and arbitration rule for the cache-to-memory arbiter
package wb_arb_types;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } arb_port_t;

    // Next grant out of IDLE: lone requester wins, a tie goes to the port not served last.
    function automatic arb_state_t arb_pick(input logic i_req, input logic d_req,
                                            input arb_port_t last);
        arb_state_t pick;
        pick = IDLE;
        if (i_req && (!d_req || last == PORT_D))
            pick = SERVE_I;
        else if (d_req)
            pick = SERVE_D;
        return pick;
    endfunction

endpackage

// File: rtl/wb_cache_arbiter_if.sv
// rtl/wb_cache_arbiter_if.sv - classic Wishbone bus bundle with master/slave views
interface wishbone #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 128,
    parameter int SEL_WIDTH  = DATA_WIDTH / 8
);
    logic                  cyc;
    logic                  stb;
    logic                  we;
    logic [ADDR_WIDTH-1:0] adr;
    logic [SEL_WIDTH-1:0]  sel;
    logic [DATA_WIDTH-1:0] dat_m;
    logic [DATA_WIDTH-1:0] dat_s;
    logic                  ack;
    logic                  rty;

    modport master (
        output cyc, stb, we, adr, sel, dat_m,
        input  dat_s, ack, rty
    );

    modport slave (
        input  cyc, stb, we, adr, sel, dat_m,
        output dat_s, ack, rty
    );
endinterface

// File: rtl/wb_cache_arbiter_sat_counter.sv
// rtl/wb_cache_arbiter_sat_counter.sv - saturating event counter used for grant statistics
module wb_arb_sat_counter #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // Count up on each pulse, sticking at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (inc && count != CNT_MAX)
            count <= count + CNT_ONE;
    end

endmodule

// File: rtl/wb_cache_arbiter.sv
// rtl/wb_cache_arbiter.sv - round-robin Wishbone arbiter between I-cache and D-cache
module wb_cache_arbiter
    import wb_arb_types::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 128,
    parameter int SEL_WIDTH  = DATA_WIDTH / 8,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    wishbone.slave               icache_wb,
    wishbone.slave               dcache_wb,
    wishbone.master              mem_wb,
    output logic [CNT_WIDTH-1:0] i_grant_count,
    output logic [CNT_WIDTH-1:0] d_grant_count
);

    arb_state_t state, state_next;
    arb_port_t  last_served, last_next;
    logic       i_req, d_req;
    logic       i_inc, d_inc;

    assign i_req = icache_wb.cyc & icache_wb.stb;
    assign d_req = dcache_wb.cyc & dcache_wb.stb;

    // Read data is broadcast; only the forwarded ACK tells a cache it is meant for it.
    assign icache_wb.dat_s = mem_wb.dat_s;
    assign dcache_wb.dat_s = mem_wb.dat_s;

    // State and round-robin pointer; reset leaves I as last served so D wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last_served <= PORT_I;
        end else begin
            state       <= state_next;
            last_served <= last_next;
        end
    end

    // Next-state: arbitrate in IDLE, return to IDLE on termination or master abort.
    always_comb begin
        state_next = state;
        last_next  = last_served;
        i_inc      = 1'b0;
        d_inc      = 1'b0;
        case (state)
            IDLE: begin
                state_next = arb_pick(i_req, d_req, last_served);
                if (state_next == SERVE_I) begin
                    last_next = PORT_I;
                    i_inc     = 1'b1;
                end else if (state_next == SERVE_D) begin
                    last_next = PORT_D;
                    d_inc     = 1'b1;
                end
            end
            SERVE_I: begin
                if (!icache_wb.cyc || mem_wb.ack || mem_wb.rty)
                    state_next = IDLE;
            end
            SERVE_D: begin
                if (!dcache_wb.cyc || mem_wb.ack || mem_wb.rty)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: forward the owner's request to memory and memory's termination to the owner.
    always_comb begin
        mem_wb.cyc    = 1'b0;
        mem_wb.stb    = 1'b0;
        mem_wb.we     = 1'b0;
        mem_wb.adr    = {ADDR_WIDTH{1'b0}};
        mem_wb.sel    = {SEL_WIDTH{1'b0}};
        mem_wb.dat_m  = {DATA_WIDTH{1'b0}};
        icache_wb.ack = 1'b0;
        icache_wb.rty = 1'b0;
        dcache_wb.ack = 1'b0;
        dcache_wb.rty = 1'b0;
        case (state)
            SERVE_I: begin
                // STB is gated by CYC so an abort fully releases the bus in the same cycle.
                mem_wb.cyc    = icache_wb.cyc;
                mem_wb.stb    = icache_wb.stb & icache_wb.cyc;
                mem_wb.we     = icache_wb.we;
                mem_wb.adr    = icache_wb.adr;
                mem_wb.sel    = icache_wb.sel;
                mem_wb.dat_m  = icache_wb.dat_m;
                icache_wb.ack = mem_wb.ack;
                icache_wb.rty = mem_wb.rty;
            end
            SERVE_D: begin
                mem_wb.cyc    = dcache_wb.cyc;
                mem_wb.stb    = dcache_wb.stb & dcache_wb.cyc;
                mem_wb.we     = dcache_wb.we;
                mem_wb.adr    = dcache_wb.adr;
                mem_wb.sel    = dcache_wb.sel;
                mem_wb.dat_m  = dcache_wb.dat_m;
                dcache_wb.ack = mem_wb.ack;
                dcache_wb.rty = mem_wb.rty;
            end
            default: ;
        endcase
    end

    wb_arb_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_i_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (i_inc),
        .count (i_grant_count)
    );

    wb_arb_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_d_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (d_inc),
        .count (d_grant_count)
    );

endmodule

// File: tb/tb_wb_cache_arbiter.sv
// tb/tb_wb_cache_arbiter.sv - self-checking bench for wb_cache_arbiter
module tb_wb_cache_arbiter;

    localparam int AW = 12;
    localparam int DW = 128;
    localparam int SW = DW / 8;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CW-1:0] i_grant_count;
    logic [CW-1:0] d_grant_count;

    wishbone #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) icache_if ();
    wishbone #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dcache_if ();
    wishbone #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_if ();

    wb_cache_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .icache_wb     (icache_if),
        .dcache_wb     (dcache_if),
        .mem_wb        (mem_if),
        .i_grant_count (i_grant_count),
        .d_grant_count (d_grant_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: which port the arbiter served last (0=I, 1=D) and grants issued per port.
    int m_last  = 0;
    int m_icnt  = 0;
    int m_dcnt  = 0;

    // Per-port request fields (index 0 = I-cache, 1 = D-cache).
    logic [AW-1:0] r_adr [2];
    logic          r_we  [2];
    logic [SW-1:0] r_sel [2];
    logic [DW-1:0] r_dat [2];

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat(input int n);
        return (n > CMAX) ? CMAX : n;
    endfunction

    task automatic chk_counts(input string tag);
        chk({tag, "_icnt"}, DW'(i_grant_count), DW'(sat(m_icnt)));
        chk({tag, "_dcnt"}, DW'(d_grant_count), DW'(sat(m_dcnt)));
    endtask

    task automatic drive_port(input int p, input logic en);
        if (p == 0) begin
            icache_if.cyc = en; icache_if.stb = en; icache_if.we = r_we[0];
            icache_if.adr = r_adr[0]; icache_if.sel = r_sel[0]; icache_if.dat_m = r_dat[0];
        end else begin
            dcache_if.cyc = en; dcache_if.stb = en; dcache_if.we = r_we[1];
            dcache_if.adr = r_adr[1]; dcache_if.sel = r_sel[1]; dcache_if.dat_m = r_dat[1];
        end
    endtask

    task automatic rand_req(input int p);
        r_adr[p] = AW'($urandom);
        r_we[p]  = 1'($urandom);
        r_sel[p] = SW'($urandom);
        r_dat[p] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    function automatic logic ack_of(input int p);
        return (p == 0) ? icache_if.ack : dcache_if.ack;
    endfunction

    function automatic logic rty_of(input int p);
        return (p == 0) ? icache_if.rty : dcache_if.rty;
    endfunction

    function automatic logic [DW-1:0] dat_of(input int p);
        return (p == 0) ? icache_if.dat_s : dcache_if.dat_s;
    endfunction

    task automatic note_grant(input int w);
        m_last = w;
        if (w == 0) m_icnt++; else m_dcnt++;
    endtask

    // Raise the chosen requests while the arbiter idles, then serve until both ports are done.
    task automatic run_batch(input bit wi, input bit wd);
        bit            pend [2];
        int            w;
        int            waits;
        bit            use_rty;
        logic [DW-1:0] rd;
        pend[0] = wi;
        pend[1] = wd;
        for (int p = 0; p < 2; p++) begin
            if (pend[p]) begin
                rand_req(p);
                drive_port(p, 1'b1);
            end
        end
        while (pend[0] || pend[1]) begin
            if (pend[0] && pend[1]) w = (m_last == 0) ? 1 : 0;
            else w = pend[0] ? 0 : 1;
            step();
            note_grant(w);
            chk("b_cyc", DW'(mem_if.cyc), DW'(1'b1));
            chk("b_adr", DW'(mem_if.adr), DW'(r_adr[w]));
            chk("b_we",  DW'(mem_if.we),  DW'(r_we[w]));
            chk("b_sel", DW'(mem_if.sel), DW'(r_sel[w]));
            chk("b_datm", mem_if.dat_m, r_dat[w]);
            chk_counts("b");
            waits = $urandom_range(0, 2);
            for (int k = 0; k < waits; k++) begin
                step();
                chk("b_wait_ack", DW'(ack_of(w)), DW'(1'b0));
                chk("b_wait_oth", DW'(ack_of(1 - w)), DW'(1'b0));
            end
            use_rty = ($urandom_range(0, 3) == 0);
            rd = {$urandom, $urandom, $urandom, $urandom};
            mem_if.ack = !use_rty;
            mem_if.rty = use_rty;
            mem_if.dat_s = rd;
            #1;
            chk("b_ack", DW'(ack_of(w)), DW'(!use_rty));
            chk("b_rty", DW'(rty_of(w)), DW'(use_rty));
            chk("b_oth_ack", DW'(ack_of(1 - w)), DW'(1'b0));
            chk("b_oth_rty", DW'(rty_of(1 - w)), DW'(1'b0));
            chk("b_dats", dat_of(w), rd);
            step();
            mem_if.ack = 1'b0;
            mem_if.rty = 1'b0;
            drive_port(w, 1'b0);
            pend[w] = 1'b0;
            #1;
            chk("b_idle_cyc", DW'(mem_if.cyc), DW'(1'b0));
        end
    endtask

    logic [DW-1:0] rdat;

    initial begin
        for (int p = 0; p < 2; p++) begin
            r_adr[p] = '0; r_we[p] = 1'b0; r_sel[p] = '0; r_dat[p] = '0;
            drive_port(p, 1'b0);
        end
        mem_if.ack = 1'b0; mem_if.rty = 1'b0; mem_if.dat_s = '0;

        // Reset state.
        repeat (2) step();
        chk("rst_cyc", DW'(mem_if.cyc), DW'(1'b0));
        chk("rst_stb", DW'(mem_if.stb), DW'(1'b0));
        chk_counts("rst");
        rst = 1'b0;
        step();

        // D-only read at 12'h040, memory ACKs in the 4th STB cycle.
        r_adr[1] = 12'h040; r_we[1] = 1'b0; r_sel[1] = '1; r_dat[1] = '0;
        drive_port(1, 1'b1);
        #1;
        chk("d0_cyc0", DW'(mem_if.cyc), DW'(1'b0));
        step();
        note_grant(1);
        chk("d0_adr", DW'(mem_if.adr), DW'(12'h040));
        chk("d0_stb", DW'(mem_if.stb), DW'(1'b1));
        chk_counts("d0");
        repeat (2) begin
            step();
            chk("d0_noack", DW'(dcache_if.ack), DW'(1'b0));
        end
        step();
        rdat = {$urandom, $urandom, $urandom, $urandom};
        mem_if.ack = 1'b1; mem_if.dat_s = rdat;
        #1;
        chk("d0_ack", DW'(dcache_if.ack), DW'(1'b1));
        chk("d0_dats", dcache_if.dat_s, rdat);
        chk("d0_iack", DW'(icache_if.ack), DW'(1'b0));
        step();
        mem_if.ack = 1'b0;
        drive_port(1, 1'b0);
        #1;
        chk("d0_idle", DW'(mem_if.cyc), DW'(1'b0));

        // Stray ACK/RTY while idle must not reach either cache.
        mem_if.ack = 1'b1; mem_if.rty = 1'b1;
        #1;
        chk("idle_iack", DW'(icache_if.ack), DW'(1'b0));
        chk("idle_drty", DW'(dcache_if.rty), DW'(1'b0));
        chk("idle_adr", DW'(mem_if.adr), DW'(0));
        step();
        mem_if.ack = 1'b0; mem_if.rty = 1'b0;
        step();
        chk_counts("idle");

        // I read in progress, D write arrives mid-transfer and waits.
        rand_req(0); r_we[0] = 1'b0;
        drive_port(0, 1'b1);
        step();
        note_grant(0);
        chk("mid_iadr", DW'(mem_if.adr), DW'(r_adr[0]));
        step();
        rand_req(1); r_we[1] = 1'b1; r_sel[1] = 16'hFFFF;
        drive_port(1, 1'b1);
        #1;
        chk("mid_dack0", DW'(dcache_if.ack), DW'(1'b0));
        chk("mid_still_i", DW'(mem_if.adr), DW'(r_adr[0]));
        step();
        rdat = {$urandom, $urandom, $urandom, $urandom};
        mem_if.ack = 1'b1; mem_if.dat_s = rdat;
        #1;
        chk("mid_iack", DW'(icache_if.ack), DW'(1'b1));
        chk("mid_dack1", DW'(dcache_if.ack), DW'(1'b0));
        step();
        mem_if.ack = 1'b0;
        drive_port(0, 1'b0);
        #1;
        chk("mid_gap", DW'(mem_if.cyc), DW'(1'b0));
        step();
        note_grant(1);
        chk("mid_dwe", DW'(mem_if.we), DW'(1'b1));
        chk("mid_dsel", DW'(mem_if.sel), DW'(16'hFFFF));
        chk("mid_dadr", DW'(mem_if.adr), DW'(r_adr[1]));
        chk_counts("mid");
        mem_if.ack = 1'b1;
        #1;
        chk("mid_dack", DW'(dcache_if.ack), DW'(1'b1));
        step();
        mem_if.ack = 1'b0;
        drive_port(1, 1'b0);

        // Granted I-cache aborts; pending D is granted after one idle cycle.
        rand_req(0);
        drive_port(0, 1'b1);
        step();
        note_grant(0);
        chk("ab_icyc", DW'(mem_if.cyc), DW'(1'b1));
        rand_req(1);
        drive_port(1, 1'b1);
        step();
        drive_port(0, 1'b0);
        #1;
        chk("ab_drop", DW'(mem_if.cyc), DW'(1'b0));
        step();
        chk("ab_idle", DW'(mem_if.cyc), DW'(1'b0));
        step();
        note_grant(1);
        chk("ab_dcyc", DW'(mem_if.cyc), DW'(1'b1));
        chk("ab_dadr", DW'(mem_if.adr), DW'(r_adr[1]));
        chk_counts("ab");
        mem_if.ack = 1'b1;
        step();
        mem_if.ack = 1'b0;
        drive_port(1, 1'b0);

        // Reset pulsed while D is being served.
        rand_req(1);
        drive_port(1, 1'b1);
        step();
        chk("rs_stb", DW'(mem_if.stb), DW'(1'b1));
        rst = 1'b1;
        mem_if.ack = 1'b1;
        #1;
        chk("rs_cyc", DW'(mem_if.cyc), DW'(1'b0));
        chk("rs_stb0", DW'(mem_if.stb), DW'(1'b0));
        chk("rs_dack", DW'(dcache_if.ack), DW'(1'b0));
        m_last = 0; m_icnt = 0; m_dcnt = 0;
        chk_counts("rs");
        #1;
        mem_if.ack = 1'b0;
        drive_port(1, 1'b0);
        rst = 1'b0;

        // Ties from reset alternate D, I, then D again.
        run_batch(1'b1, 1'b1);
        run_batch(1'b1, 1'b1);

        // Saturation of the I grant counter.
        for (int n = 0; n < 17; n++) run_batch(1'b1, 1'b0);
        chk("sat_i", DW'(i_grant_count), DW'(4'hF));

        // Randomized request patterns.
        for (int n = 0; n < 25; n++) begin
            int pat;
            pat = $urandom_range(1, 3);
            run_batch(pat[0], pat[1]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
